// File: rtl/usb_rx_pkt_if.sv
// Line-state type and receive-side bus bundle for the USB packet receiver.

package usb_rx_pkt_pkg;

  // Differential line state from the CDR, encoded as {D-, D+}.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } d_port_t;

endpackage

interface usb_rx_pkt_if
  import usb_rx_pkt_pkg::*;
#(
  parameter int unsigned LEN_W = 11
);

  logic             clk_en;
  d_port_t          rxd;
  logic [7:0]       data;
  logic             valid;
  logic             active;
  logic             eop;
  logic             error;
  logic [1:0]       err_code;
  logic [LEN_W-1:0] byte_cnt;

  // Receiver side: consumes line state, produces bytes and status.
  modport master (
    input  clk_en,
    input  rxd,
    output data,
    output valid,
    output active,
    output eop,
    output error,
    output err_code,
    output byte_cnt
  );

  // Client side: supplies line state, observes bytes and status.
  modport slave (
    output clk_en,
    output rxd,
    input  data,
    input  valid,
    input  active,
    input  eop,
    input  error,
    input  err_code,
    input  byte_cnt
  );

endinterface

// File: rtl/usb_rx_pkt.sv
// USB packet receiver: SYNC detection, NRZI decode, bit-unstuffing,
// byte assembly, EOP detection and error reporting.

module usb_rx_pkt
  import usb_rx_pkt_pkg::*;
#(
  parameter int unsigned SYNC_LEN  = 8,
  parameter int unsigned STUFF_LEN = 6,
  parameter int unsigned MAX_LEN   = 1027,
  parameter int unsigned LEN_W     = 11
) (
  input logic         clk,
  input logic         reset,
  usb_rx_pkt_if.master bus
);

  localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned CNT_W  = $clog2(STUFF_LEN + 2);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_STUFF = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_LEN   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERROR,
    S_WAIT_IDLE
  } state_t;

  state_t             state_q,    state_d;
  logic [SYNC_W-1:0]  sync_cnt_q, sync_cnt_d;
  logic [2:0]         bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0]   ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [7:0]         shift_q,    shift_d;
  logic               prev_j_q,   prev_j_d;
  logic               prev_se0_q, prev_se0_d;
  logic [7:0]         data_q,     data_d;
  logic               valid_q,    valid_d;
  logic               active_q,   active_d;
  logic               eop_q,      eop_d;
  logic               error_q,    error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;

  logic               line_j;
  logic               line_k;
  logic               line_se0;
  logic               nrzi_bit;
  logic [SYNC_W-1:0]  sync_nxt;
  logic [7:0]         byte_nxt;

  // Line decode helpers; SE1 is treated as a non-J, non-SE0 symbol.
  always_comb begin
    line_j   = (bus.rxd == LS_J);
    line_k   = (bus.rxd == LS_K);
    line_se0 = (bus.rxd == LS_SE0);
    nrzi_bit = (line_j == prev_j_q);
    sync_nxt = sync_cnt_q + SYNC_W'(1);
    byte_nxt = {nrzi_bit, shift_q[7:1]};
  end

  // Next-state and output computation; everything moves only on a bit strobe.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_q;
    prev_j_d   = prev_j_q;
    prev_se0_d = prev_se0_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    byte_cnt_d = byte_cnt_q;

    if (bus.clk_en) begin
      // Line history is tracked on every strobe, independent of state.
      prev_j_d   = line_j;
      prev_se0_d = line_se0;

      case (state_q)
        S_IDLE: begin
          if (line_k) begin
            state_d    = S_SYNC;
            sync_cnt_d = SYNC_W'(1);
          end
        end

        S_SYNC: begin
          if (sync_nxt == SYNC_W'(SYNC_LEN)) begin
            if (line_k) begin
              state_d    = S_DATA;
              byte_cnt_d = '0;
              err_code_d = ERR_NONE;
              bit_cnt_d  = '0;
              ones_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if ((sync_nxt[0] && line_k) || (!sync_nxt[0] && line_j)) begin
            sync_cnt_d = sync_nxt;
          end else begin
            // Broken SYNC is just noise: drop back silently.
            state_d = S_IDLE;
          end
        end

        S_DATA: begin
          if (line_se0) begin
            if ((bit_cnt_q == 3'd0) && (byte_cnt_q != '0)) begin
              state_d = S_EOP;
            end else begin
              state_d    = S_ERROR;
              err_code_d = ERR_ALIGN;
            end
          end else if (ones_cnt_q == CNT_W'(STUFF_LEN)) begin
            // This bit must be the stuffed zero; a one here is a stuff violation.
            if (nrzi_bit) begin
              state_d    = S_ERROR;
              err_code_d = ERR_STUFF;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            ones_cnt_d = nrzi_bit ? (ones_cnt_q + CNT_W'(1)) : '0;
            shift_d    = byte_nxt;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == LEN_W'(MAX_LEN)) begin
                state_d    = S_ERROR;
                err_code_d = ERR_LEN;
              end else begin
                data_d     = byte_nxt;
                valid_d    = 1'b1;
                byte_cnt_d = byte_cnt_q + LEN_W'(1);
              end
            end
          end
        end

        S_EOP: begin
          if (line_j) begin
            eop_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!line_se0) begin
            state_d    = S_ERROR;
            err_code_d = ERR_ALIGN;
          end
        end

        S_ERROR: begin
          error_d    = 1'b1;
          state_d    = S_WAIT_IDLE;
          idle_cnt_d = '0;
        end

        S_WAIT_IDLE: begin
          // Leave on a long enough J run, or on J right after an SE0.
          if (line_j) begin
            if (prev_se0_q || (idle_cnt_q == CNT_W'(STUFF_LEN))) begin
              state_d = S_IDLE;
            end else begin
              idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
          end else begin
            idle_cnt_d = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    active_d = (state_d == S_DATA) || (state_d == S_EOP) ||
               (state_d == S_ERROR) || (state_d == S_WAIT_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync_cnt_q <= '0;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      idle_cnt_q <= '0;
      shift_q    <= '0;
      prev_j_q   <= 1'b0;
      prev_se0_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      prev_j_q   <= prev_j_d;
      prev_se0_q <= prev_se0_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      eop_q      <= eop_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.active   = active_q;
  assign bus.eop      = eop_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_code_q;
  assign bus.byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_usb_rx_pkt.sv
// Directed bench for usb_rx_pkt: three instances (default, MAX_LEN=4,
// SYNC_LEN=32) share a line driver; expected bytes go through a queue.

module tb_usb_rx_pkt;
  import usb_rx_pkt_pkg::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    clk_en;
  d_port_t line;
  int      sel;

  int checks;
  int errors;

  logic [7:0] exp_q[$];
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] got2[$];
  int nerr0, nerr1, nerr2;
  int neop0, neop1, neop2;

  logic lvl_j;
  int   ones;

  always #5 clk = ~clk;

  usb_rx_pkt_if #(.LEN_W(11)) b0 ();
  usb_rx_pkt_if #(.LEN_W(3))  b1 ();
  usb_rx_pkt_if #(.LEN_W(11)) b2 ();

  assign b0.clk_en = clk_en;
  assign b1.clk_en = clk_en;
  assign b2.clk_en = clk_en;
  assign b0.rxd = (sel == 0) ? line : LS_J;
  assign b1.rxd = (sel == 1) ? line : LS_J;
  assign b2.rxd = (sel == 2) ? line : LS_J;

  usb_rx_pkt #(.SYNC_LEN(8), .STUFF_LEN(6), .MAX_LEN(1027), .LEN_W(11))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  usb_rx_pkt #(.SYNC_LEN(8), .STUFF_LEN(6), .MAX_LEN(4), .LEN_W(3))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  usb_rx_pkt #(.SYNC_LEN(32), .STUFF_LEN(6), .MAX_LEN(1027), .LEN_W(11))
    u2 (.clk(clk), .reset(reset), .bus(b2));

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (b0.valid) got0.push_back(b0.data);
    if (b0.error) nerr0++;
    if (b0.eop)   neop0++;
  end
  always @(negedge clk) begin
    if (b1.valid) got1.push_back(b1.data);
    if (b1.error) nerr1++;
    if (b1.eop)   neop1++;
  end
  always @(negedge clk) begin
    if (b2.valid) got2.push_back(b2.data);
    if (b2.error) nerr2++;
    if (b2.eop)   neop2++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int n_got(int k);
    case (k)
      0:       return got0.size();
      1:       return got1.size();
      default: return got2.size();
    endcase
  endfunction

  function automatic logic [7:0] pop_got(int k);
    case (k)
      0:       return got0.pop_front();
      1:       return got1.pop_front();
      default: return got2.pop_front();
    endcase
  endfunction

  function automatic int n_err(int k);
    case (k)
      0:       return nerr0;
      1:       return nerr1;
      default: return nerr2;
    endcase
  endfunction

  function automatic int n_eop(int k);
    case (k)
      0:       return neop0;
      1:       return neop1;
      default: return neop2;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare everything the monitor saw against the scoreboard queue.
  task automatic drain(string tag, int k);
    int ne;
    int ng;
    ne = exp_q.size();
    ng = n_got(k);
    chk({tag, "_count"}, 32'(ng), 32'(ne));
    while ((exp_q.size() > 0) && (n_got(k) > 0))
      chk({tag, "_data"}, 32'(pop_got(k)), 32'(exp_q.pop_front()));
    exp_q.delete();
    while (n_got(k) > 0) void'(pop_got(k));
  endtask

  // One bit time: strobe for one clock, then three idle clocks.
  task automatic sym(d_port_t s);
    line   = s;
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) sym(LS_J);
    lvl_j = 1'b1;
  endtask

  task automatic send_sync(int n);
    for (int i = 1; i <= n; i++) sym(((i == n) || (i % 2 == 1)) ? LS_K : LS_J);
    lvl_j = 1'b0;
    ones  = 0;
  endtask

  // NRZI encode one bit; optionally insert a stuffed zero after six ones.
  task automatic send_bit(bit b, bit stuff);
    if (!b) lvl_j = !lvl_j;
    sym(lvl_j ? LS_J : LS_K);
    ones = b ? ones + 1 : 0;
    if (stuff && (ones == 6)) begin
      lvl_j = !lvl_j;
      sym(lvl_j ? LS_J : LS_K);
      ones = 0;
    end
  endtask

  task automatic send_byte(logic [7:0] b, bit push);
    if (push) exp_q.push_back(b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b1);
  endtask

  task automatic send_eop();
    sym(LS_SE0);
    sym(LS_SE0);
    sym(LS_J);
    lvl_j = 1'b1;
  endtask

  // Directed sequence.
  initial begin
    int e0;
    int o0;
    logic [7:0] junk;
    checks = 0;
    errors = 0;
    sel    = 0;
    line   = LS_J;
    clk_en = 1'b0;
    lvl_j  = 1'b1;
    ones   = 0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("rst_data",     32'(b0.data),     32'h0);
    chk("rst_valid",    32'(b0.valid),    32'h0);
    chk("rst_active",   32'(b0.active),   32'h0);
    chk("rst_eop",      32'(b0.eop),      32'h0);
    chk("rst_error",    32'(b0.error),    32'h0);
    chk("rst_err_code", 32'(b0.err_code), 32'h0);
    chk("rst_byte_cnt", 32'(b0.byte_cnt), 32'h0);
    idle(4);

    // Single byte 0xA5 with clean EOP.
    e0 = n_err(0); o0 = n_eop(0);
    send_sync(8);
    send_byte(8'hA5, 1'b1);
    chk("a5_active_mid", 32'(b0.active), 32'h1);
    send_eop();
    drain("a5", 0);
    chk("a5_eop",      32'(n_eop(0) - o0), 32'd1);
    chk("a5_err",      32'(n_err(0) - e0), 32'd0);
    chk("a5_byte_cnt", 32'(b0.byte_cnt),   32'd1);
    chk("a5_data",     32'(b0.data),       32'hA5);
    chk("a5_active",   32'(b0.active),     32'h0);
    idle(3);

    // 0xFF then 0x01 with a stuffed zero inside.
    e0 = n_err(0);
    send_sync(8);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_eop();
    drain("stuff_ok", 0);
    chk("stuff_ok_err", 32'(n_err(0) - e0), 32'd0);
    chk("stuff_ok_cnt", 32'(b0.byte_cnt),   32'd2);
    idle(3);

    // Seven decoded ones: stuff error, then junk, idle and a fresh packet.
    e0 = n_err(0);
    send_sync(8);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    junk = 8'hC6;
    for (int i = 0; i < 8; i++) send_bit(junk[i], 1'b0);
    idle(10);
    drain("stuff_err", 0);
    chk("stuff_err_pulses", 32'(n_err(0) - e0), 32'd1);
    chk("stuff_err_code",   32'(b0.err_code),   32'd1);
    chk("stuff_err_active", 32'(b0.active),     32'h0);
    send_sync(8);
    send_byte(8'h5A, 1'b1);
    send_eop();
    drain("after_err", 0);
    chk("after_err_code", 32'(b0.err_code), 32'd0);
    idle(3);

    // SE0 after three data bits: alignment error, exit on SE0 then J.
    e0 = n_err(0);
    send_sync(8);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    sym(LS_SE0);
    sym(LS_SE0);
    chk("align_pulses", 32'(n_err(0) - e0), 32'd1);
    chk("align_code",   32'(b0.err_code),   32'd2);
    chk("align_wait",   32'(b0.active),     32'h1);
    sym(LS_J);
    lvl_j = 1'b1;
    chk("align_exit",   32'(b0.active),     32'h0);
    drain("align", 0);
    idle(3);

    // MAX_LEN=4 instance: fifth byte is a length error.
    sel = 1;
    idle(2);
    e0 = n_err(1);
    send_sync(8);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(10);
    drain("maxlen", 1);
    chk("maxlen_pulses", 32'(n_err(1) - e0), 32'd1);
    chk("maxlen_code",   32'(b1.err_code),   32'd3);
    chk("maxlen_cnt",    32'(b1.byte_cnt),   32'd4);
    chk("maxlen_data",   32'(b1.data),       32'h44);

    // SYNC_LEN=32 instance: corrupted SYNC is dropped silently.
    sel = 2;
    idle(2);
    e0 = n_err(2);
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) sym(LS_J);
      else sym(((i == 32) || (i % 2 == 1)) ? LS_K : LS_J);
    end
    idle(4);
    drain("sync32_bad", 2);
    chk("sync32_bad_err",    32'(n_err(2) - e0), 32'd0);
    chk("sync32_bad_active", 32'(b2.active),     32'h0);
    send_sync(32);
    send_byte(8'h3C, 1'b1);
    send_eop();
    drain("sync32_good", 2);
    chk("sync32_data", 32'(b2.data), 32'h3C);
    chk("sync32_eop",  32'(n_eop(2)), 32'd1);

    // Reset mid-byte, coincident with a strobe.
    sel = 0;
    idle(2);
    e0 = n_err(0); o0 = n_eop(0);
    send_sync(8);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    line   = LS_K;
    clk_en = 1'b1;
    reset  = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clk_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_data",     32'(b0.data),     32'h0);
    chk("mid_rst_valid",    32'(b0.valid),    32'h0);
    chk("mid_rst_active",   32'(b0.active),   32'h0);
    chk("mid_rst_eop",      32'(b0.eop),      32'h0);
    chk("mid_rst_error",    32'(b0.error),    32'h0);
    chk("mid_rst_err_code", 32'(b0.err_code), 32'h0);
    chk("mid_rst_byte_cnt", 32'(b0.byte_cnt), 32'h0);
    @(posedge clk);
    #1;
    idle(3);
    send_sync(8);
    send_byte(8'hC3, 1'b1);
    send_eop();
    drain("post_rst", 0);
    chk("post_rst_cnt", 32'(b0.byte_cnt),   32'd1);
    chk("post_rst_eop", 32'(n_eop(0) - o0), 32'd1);
    chk("post_rst_err", 32'(n_err(0) - e0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt.md
USB_RX_PKT -- requirements
Module: usb_rx_pkt

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 8, meaning SYNC field length in bit times; legal values 8 and 32.
REQ-002 SHALL have parameter STUFF_LEN, default 6, meaning the number of consecutive decoded ones after which a stuffed zero is expected.
REQ-003 SHALL have parameter MAX_LEN, default 1027, meaning the maximum number of bytes per packet after SYNC.
REQ-004 SHALL have parameter LEN_W, default 11, meaning the width of byte_cnt; LEN_W SHALL satisfy 2**LEN_W > MAX_LEN.
REQ-005 clk  input  1  system clock (24 MHz).
REQ-006 reset  input  1  reset: synchronous, active-high.
REQ-007 clk_en  input  1  bit-time strobe from CDR.
REQ-008 rxd  input  d_port_t  line state from CDR (J, K, SE0).
REQ-009 data  output  8  received byte, held until the next byte completes.
REQ-010 valid  output  1  one-clk pulse per byte.
REQ-011 active  output  1  packet in progress.
REQ-012 eop  output  1  one-clk pulse on good end of packet.
REQ-013 error  output  1  one-clk pulse on error.
REQ-014 err_code  output  2  error cause: 0 none, 1 stuff, 2 alignment, 3 length.
REQ-015 byte_cnt  output  LEN_W  bytes delivered in the current or last packet.

Function
REQ-016 SHALL advance all state, counters and shift registers only in cycles with clk_en=1; valid, eop and error SHALL be registered as (condition & clk_en), giving a 1-clk pulse in the cycle after the strobe.
REQ-017 SHALL implement the states IDLE, SYNC, DATA, EOP, ERROR and WAIT_IDLE.
REQ-018 IDLE: on K SHALL go to SYNC with sync count 1; on J or SE0 SHALL remain in IDLE.
REQ-019 SYNC: bit times 2..SYNC_LEN-1 SHALL alternate J,K (even bit times J, odd bit times K); bit SYNC_LEN SHALL be K; any mismatch or SE0 SHALL return to IDLE silently, with no error pulse.
REQ-020 SYNC: on a correct final K, SHALL go to DATA, clear byte_cnt and err_code, clear the bit counter and clear the ones counter.
REQ-021 NRZI decoding: the decoded bit SHALL be 1 when j equals the previous j, where previous j is sampled on every strobe and resets to 0.
REQ-022 Bit stuffing: after STUFF_LEN consecutive decoded ones, the next bit SHALL be discarded if it is 0; if it is 1, SHALL go to ERROR with err_code=1.
REQ-023 DATA: non-stuff bits SHALL shift in LSB first; a 3-bit counter SHALL count bits 0..7.
REQ-024 On the 8th bit, SHALL load data, pulse valid and increment byte_cnt.
REQ-025 If byte_cnt already equals MAX_LEN when the 8th bit arrives, SHALL instead go to ERROR with err_code=3, with no valid pulse and data unchanged.
REQ-026 DATA, SE0 with bit counter 0 and byte_cnt>0: SHALL go to EOP.
REQ-027 DATA, SE0 with bit counter non-zero or byte_cnt=0: SHALL go to ERROR with err_code=2.
REQ-028 EOP: SHALL stay while SE0; on J SHALL pulse eop and go to IDLE; on K SHALL go to ERROR with err_code=2.
REQ-029 ERROR: SHALL last one bit time, pulse error, then go to WAIT_IDLE; err_code SHALL hold until the next successful SYNC.
REQ-030 WAIT_IDLE: SHALL return to IDLE after STUFF_LEN+1 consecutive J bit times, or after SE0 followed by J.
REQ-031 active SHALL be 1 in DATA, EOP, ERROR and WAIT_IDLE, and 0 in IDLE and SYNC.
REQ-032 byte_cnt SHALL saturate at MAX_LEN and hold its last value until the next SYNC completes.

Reset
REQ-033 reset SHALL take priority over clk_en in all cycles.
REQ-034 reset SHALL place the state in IDLE and clear data, valid, active, eop, error, err_code, byte_cnt, all internal counters and the NRZI history.
REQ-035 Reset mid-packet SHALL abort the packet with no eop or error pulse; the next packet SHALL require a full SYNC.

Verification
REQ-036 SYNC KJKJKJKK, then byte 0xA5 NRZI-encoded, then SE0,SE0,J -> exactly one valid with data=0xA5; eop pulses once; byte_cnt=1; active drops.
REQ-037 Byte 0xFF followed by 0x01 with a correctly stuffed zero after six ones -> data 0xFF then 0x01; exactly two valid pulses; no error.
REQ-038 Seven consecutive decoded ones inside DATA -> one error pulse with err_code=1; no further valid until after an idle period and a new SYNC.
REQ-039 SE0 after 3 data bits -> error pulse with err_code=2; WAIT_IDLE exits after the following J.
REQ-040 MAX_LEN=4, send 5 bytes -> 4 valid pulses, then error with err_code=3; byte_cnt=4.
REQ-041 SYNC_LEN=32 with one corrupted SYNC bit -> return to IDLE with no error pulse; a following correct 32-bit SYNC and byte 0x3C -> data=0x3C.
REQ-042 reset asserted mid-byte -> all outputs 0 on the next clk; a subsequent clean packet is received correctly.
